// File: rtl/matrix_mem_responder.sv
// Word-addressed RAM with a 1-cycle read port and a small in-order write buffer.
// Buffered writes drain to RAM in cycles with no read; reads see the newest buffered data.
module matrix_mem_responder #(
   parameter int WIDTH       = 32,
   parameter int INDEX_W     = 10,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_req,
   input  logic [WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_full,
   output logic             wr_empty,
   input  logic             err_clr,
   output logic             ovf_err,
   output logic             range_err
);
   localparam int PW    = $clog2(WFIFO_DEPTH);
   localparam int DEPTH = 1 << INDEX_W;

   logic [WIDTH-1:0]   ram [DEPTH];
   logic [INDEX_W-1:0] fIdx [WFIFO_DEPTH];
   logic [WIDTH-1:0]   fData [WFIFO_DEPTH];
   logic [PW-1:0]      head, tail;
   logic [PW:0]        count;

   logic [INDEX_W-1:0] rdIdx, wrIdx;
   logic               rdInRange, wrInRange;
   logic               push, pop;
   logic               fwdHit;
   logic [WIDTH-1:0]   fwdData;
   logic               unusedBits;

   assign rdIdx     = rd_addr[INDEX_W+1:2];
   assign wrIdx     = wr_addr[INDEX_W+1:2];
   assign rdInRange = (rd_addr[WIDTH-1:INDEX_W+2] == '0);
   assign wrInRange = (wr_addr[WIDTH-1:INDEX_W+2] == '0);
   assign unusedBits = ^{rd_addr[1:0], wr_addr[1:0]};

   assign wr_full  = (count == (PW+1)'(WFIFO_DEPTH));
   assign wr_empty = (count == '0);
   assign push     = wr_en && !wr_full && wrInRange;
   assign pop      = !rd_req && !wr_empty;

   // Walk oldest to newest so the last hit is the newest matching entry.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      for (int k = 0; k < WFIFO_DEPTH; k++) begin
         if (((PW+1)'(k) < count) && (fIdx[head + PW'(k)] == rdIdx)) begin
            fwdHit  = 1'b1;
            fwdData = fData[head + PW'(k)];
         end
      end
   end

   // Storage arrays carry no reset; the buffer is emptied by clearing the pointers.
   always_ff @(posedge clk) begin
      if (rst_n && pop)
         ram[fIdx[head]] <= fData[head];
      if (rst_n && push) begin
         fIdx[tail]  <= wrIdx;
         fData[tail] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         ovf_err   <= 1'b0;
         range_err <= 1'b0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count    <= count + (PW+1)'(push) - (PW+1)'(pop);
         rd_valid <= rd_req;
         if (rd_req)
            rd_data <= !rdInRange ? '0 : (fwdHit ? fwdData : ram[rdIdx]);
         ovf_err   <= (ovf_err && !err_clr) || (wr_en && wr_full);
         range_err <= (range_err && !err_clr) || (rd_req && !rdInRange) ||
                      (wr_en && !wrInRange);
      end
   end
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Randomized bench for matrix_mem_responder against a queue-based memory model,
// with directed scenarios pinned by literal expectations.
module tb_matrix_mem_responder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_req, wr_en, err_clr;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [31:0] rd_data;
   logic        rd_valid, wr_full, wr_empty, ovf_err, range_err;

   matrix_mem_responder #(.WIDTH(32), .INDEX_W(10), .WFIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_full(wr_full), .wr_empty(wr_empty),
      .err_clr(err_clr), .ovf_err(ovf_err), .range_err(range_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  idx;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic [31:0] mRam [1024];
   bit          mKnown [1024];
   logic [31:0] expData;
   bit          expDataKnown;
   logic        expValid, expOvf, expRange;
   bit          checkEn = 0;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the reference model by one clock edge using the inputs present before it.
   task automatic modelEdge(input bit rr, input logic [31:0] ra, input bit we,
                            input logic [31:0] wa, input logic [31:0] wd,
                            input bit ec, input bit rs);
      bit full, rIn, wIn, hit;
      if (rs) begin
         q.delete();
         expValid = 0; expData = 0; expDataKnown = 1;
         expOvf = 0; expRange = 0;
         return;
      end
      full = (q.size() == 4);
      rIn  = (ra[31:12] == 0);
      wIn  = (wa[31:12] == 0);
      expValid = rr;
      if (rr) begin
         if (!rIn) begin
            expData = 0; expDataKnown = 1;
         end else begin
            hit = 0;
            for (int i = q.size() - 1; i >= 0 && !hit; i--)
               if (q[i].idx == ra[11:2]) begin
                  hit = 1; expData = q[i].d; expDataKnown = 1;
               end
            if (!hit) begin
               expData = mRam[ra[11:2]]; expDataKnown = mKnown[ra[11:2]];
            end
         end
      end
      if (!rr && q.size() > 0) begin
         mRam[q[0].idx] = q[0].d;
         mKnown[q[0].idx] = 1;
         void'(q.pop_front());
      end
      if (we && !full && wIn) q.push_back('{idx: wa[11:2], d: wd});
      expOvf   = (expOvf && !ec) || (we && full);
      expRange = (expRange && !ec) || (rr && !rIn) || (we && !wIn);
   endtask

   task automatic step(input bit rr, input logic [31:0] ra, input bit we,
                       input logic [31:0] wa, input logic [31:0] wd,
                       input bit ec, input bit rs);
      rd_req = rr; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
      err_clr = ec; rst_n = !rs;
      @(posedge clk);
      modelEdge(rr, ra, we, wa, wd, ec, rs);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] rndAddr();
      logic [31:0] a;
      a = {20'b0, 5'(0), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) a[$urandom_range(12, 31)] = 1'b1;
      return a;
   endfunction

   always @(negedge clk) begin
      if (checkEn) begin
         chk("rd_valid", 32'(rd_valid), 32'(expValid));
         if (expDataKnown) chk("rd_data", rd_data, expData);
         chk("wr_full", 32'(wr_full), 32'(q.size() == 4));
         chk("wr_empty", 32'(wr_empty), 32'(q.size() == 0));
         chk("ovf_err", 32'(ovf_err), 32'(expOvf));
         chk("range_err", 32'(range_err), 32'(expRange));
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin mRam[i] = 0; mKnown[i] = 0; end
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("reset_rd_valid", 32'(rd_valid), 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_wr_empty", 32'(wr_empty), 1);
      chk("reset_flags", {30'b0, ovf_err, range_err}, 0);
      checkEn = 1;

      // Basic write/read with byte-offset aliasing
      step(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
      idle(1);
      step(1, 32'h10, 0, 0, 0, 0, 0);
      chk("basic_valid", 32'(rd_valid), 1);
      chk("basic_data", rd_data, 32'hDEADBEEF);
      step(1, 32'h13, 0, 0, 0, 0, 0);
      chk("basic_alias", rd_data, 32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("rd_valid_drop", 32'(rd_valid), 0);
      chk("rd_data_hold", rd_data, 32'hDEADBEEF);

      // Forwarding while reads hold off the drain
      step(1, 32'h10, 1, 32'h40, 32'h1, 0, 0);
      step(1, 32'h10, 1, 32'h40, 32'h2, 0, 0);
      step(1, 32'h40, 0, 0, 0, 0, 0);
      chk("fwd_newest", rd_data, 32'h2);
      chk("fwd_not_empty", 32'(wr_empty), 0);
      idle(2);
      chk("fwd_drained", 32'(wr_empty), 1);

      // Overflow
      for (int i = 0; i < 5; i++) begin
         step(1, 32'h10, 1, 32'h50 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0);
         if (i == 3) chk("ovf_full", 32'(wr_full), 1);
      end
      chk("ovf_flag", 32'(ovf_err), 1);
      idle(3);
      chk("ovf_not_yet_empty", 32'(wr_empty), 0);
      idle(1);
      chk("ovf_empty", 32'(wr_empty), 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 32'h50 + 32'(4 * i), 0, 0, 0, 0, 0);
         chk("ovf_readback", rd_data, 32'hA0 + 32'(i));
      end
      step(1, 32'h60, 0, 0, 0, 0, 0);
      chk("ovf_dropped", 32'(rd_data == 32'hA4), 0);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("ovf_clr", 32'(ovf_err), 0);

      // Out-of-range access
      step(1, 32'h1000, 0, 0, 0, 0, 0);
      chk("range_data", rd_data, 0);
      chk("range_valid", 32'(rd_valid), 1);
      chk("range_flag", 32'(range_err), 1);
      step(1, 32'h10, 1, 32'h1000, 32'h55, 0, 0);
      chk("range_wr_dropped", 32'(wr_empty), 1);
      step(0, 0, 0, 0, 0, 1, 0);

      // Same-cycle read/write hazard
      step(0, 0, 1, 32'h20, 32'hA, 0, 0);
      idle(1);
      step(1, 32'h20, 1, 32'h20, 32'hB, 0, 0);
      chk("hazard_old", rd_data, 32'hA);
      step(1, 32'h20, 0, 0, 0, 0, 0);
      chk("hazard_new", rd_data, 32'hB);

      // Reset with buffered writes and a pending read
      step(0, 0, 1, 32'h70, 32'h11, 0, 0);
      idle(1);
      step(1, 32'h10, 1, 32'h70, 32'h22, 0, 0);
      step(1, 32'h10, 1, 32'h74, 32'h33, 0, 0);
      step(1, 32'h10, 1, 32'h1000, 32'h44, 0, 0);
      step(1, 32'h10, 1, 32'h78, 32'h44, 0, 0);
      step(1, 32'h70, 0, 0, 0, 0, 1);
      chk("rst_valid", 32'(rd_valid), 0);
      chk("rst_empty", 32'(wr_empty), 1);
      chk("rst_flags", {30'b0, ovf_err, range_err}, 0);
      step(1, 32'h70, 0, 0, 0, 0, 0);
      chk("rst_ram_kept", rd_data, 32'h11);

      // Seed a small address pool so every random read has a known answer
      for (int i = 0; i < 32; i++) step(0, 0, 1, 32'(4 * i), $urandom, 0, 0);
      idle(2);

      for (int n = 0; n < 3000; n++)
         step($urandom_range(0, 1), rndAddr(), $urandom_range(0, 1), rndAddr(), $urandom,
              $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);

      idle(6);
      checkEn = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
